frac_baud_gen: RTL
==================

Name: frac_baud_gen

Overview:
Parametrised fractional baud-rate generator for the SPI/UART/GPIO peripherals. A fixed-point divisor N (integer.fraction) produces event spacings of floor(N) or ceil(N) source clocks, averaging exactly N. Three output modes are supported: single-cycle tick, toggled clock, and oversample. `enable` is a synchronous clock-enable; the clock is never gated.

Parameters:
IW, 24, integer bits of divisor
FW, 8, fractional bits of divisor (N = divisor / 2^FW)
OSR_W, 5, width of oversample ratio field

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  synchronous count enable
load  in  1  one-cycle strobe: latch divisor, restart, arm
divisor  in  IW+FW  fixed-point divisor N
mode  in  2  00 TICK, 01 TOGGLE, 10 OVERSAMPLE, 11 = TICK
osr  in  OSR_W  oversample ratio minus 1 (tick every osr+1 sub-ticks)
tick  out  1  one-cycle pulse, baud event
sub_tick  out  1  one-cycle pulse per raw event (OVERSAMPLE only)
clk_out  out  1  generated clock (TOGGLE/OVERSAMPLE)
armed  out  1  generator running
div_err  out  1  divisor < 1.0 (clamped)
acc_int  out  IW+1  integer part of accumulator (debug)

Behaviour:
- Reset (reset=0, async): acc=0, os_cnt=0, armed=0, tick=0, sub_tick=0, clk_out=0, div_err=0, acc_int=0.
- Clamping: Ne = max(divisor, 1.0), where 1.0 = 1<<FW.
- div_err is registered every cycle (enable-independent) as (divisor < 1<<FW).
- acc width is IW+FW+1; there is no overflow, since acc < 1+Ne always.
- load (synchronous, highest priority, independent of enable):
  - acc=Ne, os_cnt=0, clk_out=0, tick=0, sub_tick=0, armed=1.
  - A load mid-operation restarts phase immediately; no pulse is emitted in the load cycle.
- Enabled, armed cycle without load:
  - Event condition: acc < 2.0 (integer part <= 1).
  - On event: acc = acc - 1.0 + Ne, using the live divisor. A divisor change without load takes effect at the next event reload.
  - Otherwise: acc = acc - 1.0.
- Outputs are registered. Pulses go high in the cycle after the edge that evaluated the event and last exactly one clock.
  - TICK: tick=1 per event; clk_out held 0; sub_tick 0.
  - TOGGLE: tick=1 per event; clk_out inverts per event (period 2N); sub_tick 0.
  - OVERSAMPLE: sub_tick=1 per event; os_cnt increments per event.
    - When os_cnt==osr: os_cnt=0, tick=1, clk_out inverts.
    - osr=0 gives tick on every event.
- A mode change takes effect at the next event. os_cnt is cleared when mode != OVERSAMPLE.
- enable=0 or armed=0: acc, os_cnt, clk_out hold; tick=sub_tick=0. Pulses never stretch across stalls.
- First event after load with integer N: tick asserts N clocks after the load edge (all enabled), then every N.
- Fractional N: intervals alternate floor/ceil. The sum over 2^FW events equals exactly 2^FW*N cycles (no drift).
- Simultaneous load and event: load wins, no pulse.
- acc_int = acc[IW+FW:FW], registered.

Test Plan:
1. FW=8, divisor=0x400 (4.0), mode TICK, load then enable=1 -> tick first asserts 4 clocks after load edge, then every 4 clocks; acc_int cycles 4,3,2,1.
2. divisor=0x280 (2.5), TICK -> tick intervals alternate 3,2. Exactly 20 ticks in 50 cycles; no drift over 1000 cycles.
3. divisor=0x400, TOGGLE -> clk_out period 8 clocks, 50% duty, first rise 4 clocks after load.
4. divisor=0x400, OVERSAMPLE, osr=15 -> sub_tick every 4 clocks, tick and clk_out toggle every 64 clocks.
5. Stall and restart:
   - Deassert enable 3 cycles mid-interval -> tick delayed exactly 3 cycles, never 2 cycles wide.
   - load with divisor=0x300 mid-interval -> no pulse; next tick 3 clocks later.
6. divisor=0x080 (0.5) -> div_err=1; tick every clock.
   - Assert reset low asynchronously mid-operation -> all outputs 0 immediately, armed=0, no ticks until next load.

Source files
------------

// File: rtl/frac_baud_gen.sv
// Fractional baud-rate generator: a fixed-point divisor sets the event spacing to floor(N)/ceil(N) clocks,
// averaging exactly N. Events are presented as ticks, a toggled clock, or oversample sub-ticks.
module frac_baud_gen #(
    parameter int IW    = 24,
    parameter int FW    = 8,
    parameter int OSR_W = 5
) (
    input  logic                 clock_i,
    input  logic                 reset_ni,
    input  logic                 enable_i,
    input  logic                 load_i,
    input  logic [IW+FW-1:0]     divisor_i,
    input  logic [1:0]           mode_i,
    input  logic [OSR_W-1:0]     osr_i,
    output logic                 tick_o,
    output logic                 sub_tick_o,
    output logic                 clk_out_o,
    output logic                 armed_o,
    output logic                 div_err_o,
    output logic [IW:0]          acc_int_o
);

    localparam int AW = IW + FW + 1;
    localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1} << FW;
    localparam logic [AW-1:0] TWO = ONE << 1;

    typedef enum logic [1:0] {
        MODE_TICK     = 2'b00,
        MODE_TOGGLE   = 2'b01,
        MODE_OVS      = 2'b10,
        MODE_TICK_ALT = 2'b11
    } mode_e;

    logic [AW-1:0]    acc_q, acc_d;
    logic [OSR_W-1:0] os_cnt_q, os_cnt_d;
    logic             tick_q, tick_d;
    logic             sub_tick_q, sub_tick_d;
    logic             clk_out_q, clk_out_d;
    logic             armed_q, armed_d;
    logic             div_err_q, div_err_d;

    logic [AW-1:0]    div_ext;
    logic [AW-1:0]    ne;
    logic             div_lt_one;
    logic             event_hit;
    mode_e            mode;

    assign div_ext    = {1'b0, divisor_i};
    assign div_lt_one = (div_ext < ONE);
    assign ne         = div_lt_one ? ONE : div_ext;
    assign event_hit  = (acc_q < TWO);
    assign mode       = mode_e'(mode_i);

    always_comb begin
        acc_d      = acc_q;
        os_cnt_d   = os_cnt_q;
        clk_out_d  = clk_out_q;
        armed_d    = armed_q;
        tick_d     = 1'b0;
        sub_tick_d = 1'b0;
        div_err_d  = div_lt_one;

        if (load_i) begin
            acc_d     = ne;
            os_cnt_d  = '0;
            clk_out_d = 1'b0;
            armed_d   = 1'b1;
        end else if (enable_i && armed_q) begin
            if (mode != MODE_OVS) begin
                os_cnt_d = '0;
            end
            if (event_hit) begin
                // Reload uses the live divisor, so an unloaded divisor change lands here.
                acc_d = acc_q - ONE + ne;
                case (mode)
                    MODE_TOGGLE: begin
                        tick_d    = 1'b1;
                        clk_out_d = ~clk_out_q;
                    end
                    MODE_OVS: begin
                        sub_tick_d = 1'b1;
                        // >= rather than == so a shrinking osr cannot leave the count stranded above it.
                        if (os_cnt_q >= osr_i) begin
                            os_cnt_d  = '0;
                            tick_d    = 1'b1;
                            clk_out_d = ~clk_out_q;
                        end else begin
                            os_cnt_d = os_cnt_q + OSR_W'(1);
                        end
                    end
                    default: begin
                        tick_d    = 1'b1;
                        clk_out_d = 1'b0;
                    end
                endcase
            end else begin
                acc_d = acc_q - ONE;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            acc_q      <= '0;
            os_cnt_q   <= '0;
            tick_q     <= 1'b0;
            sub_tick_q <= 1'b0;
            clk_out_q  <= 1'b0;
            armed_q    <= 1'b0;
            div_err_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            os_cnt_q   <= os_cnt_d;
            tick_q     <= tick_d;
            sub_tick_q <= sub_tick_d;
            clk_out_q  <= clk_out_d;
            armed_q    <= armed_d;
            div_err_q  <= div_err_d;
        end
    end

    assign tick_o     = tick_q;
    assign sub_tick_o = sub_tick_q;
    assign clk_out_o  = clk_out_q;
    assign armed_o    = armed_q;
    assign div_err_o  = div_err_q;
    assign acc_int_o  = acc_q[AW-1:FW];

endmodule
